// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC sequencer: FSM state encoding,
// default reset PC and the sequential fetch increment.
package pc_seq_pkg;

  typedef enum logic [2:0] {
    StBoot,
    StFetch,
    StWait,
    StRedirect,
    StHalt
  } pc_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned PC_INC           = 4;

endpackage

// File: rtl/redirect_buffer.sv
// Single-entry pending-redirect store: a valid bit plus the buffered target.
// A write always overwrites the entry, so the youngest redirect wins; a
// write in the same cycle as a clear keeps the new entry.
module redirect_buffer
  import pc_seq_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_i,
  input  logic [XLEN-1:0] wr_target_i,
  input  logic            clr_i,
  output logic            valid_o,
  output logic [XLEN-1:0] target_o
);

  logic            valid_q;
  logic [XLEN-1:0] target_q;

  // Capture on write, drop on clear, write has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      target_q <= '0;
    end else if (wr_i) begin
      valid_q  <= 1'b1;
      target_q <= wr_target_i;
    end else if (clr_i) begin
      valid_q  <= 1'b0;
    end
  end

  assign valid_o  = valid_q;
  assign target_o = target_q;

endmodule

// File: rtl/pc_sequencer.sv
// Instruction-fetch PC sequencer. Drives a req/ready fetch port, follows
// sequential and redirected control flow, and halts on request.
// Optional feature: define PC_MISALIGN_TRAP_EN to trap (and halt) on a taken
// redirect to a non word-aligned target instead of silently aligning it.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned    XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            stall,
  input  logic            br_valid,
  input  logic            next_pc_src,
  input  logic [XLEN-1:0] br_target,
  input  logic            halt_req,
  output logic [XLEN-1:0] pc,
  output logic            flush,
  output logic            halted
`ifdef PC_MISALIGN_TRAP_EN
  ,
  output logic            misalign_trap
`endif
);

  localparam logic [XLEN-1:0] AlignMask = ~{{(XLEN - 2){1'b0}}, 2'b11};

  pc_state_e       state_q;
  logic [XLEN-1:0] pc_q;
  logic            halt_pend_q;

  logic            active;
  logic            taken;
  logic            hs;
  logic            bad_tgt;
  logic            halt_now;
  logic [XLEN-1:0] tgt;
  logic [XLEN-1:0] pc_inc;
  logic            buf_wr;
  logic            buf_clr;
  logic            buf_valid;
  logic [XLEN-1:0] buf_target;

  // Fetch request: withheld by stall only before a request is committed.
  always_comb begin
    imem_req = 1'b0;
    case (state_q)
      StFetch:            imem_req = ~stall;
      StWait, StRedirect: imem_req = 1'b1;
      default:            imem_req = 1'b0;
    endcase
  end

  // Redirect decode, alignment and buffer control.
  always_comb begin
    active   = (state_q == StFetch) || (state_q == StWait) || (state_q == StRedirect);
    taken    = active && br_valid && next_pc_src;
    hs       = imem_req && imem_ready;
    tgt      = br_target & AlignMask;
    pc_inc   = pc_q + XLEN'(PC_INC);
    halt_now = halt_req || halt_pend_q;
`ifdef PC_MISALIGN_TRAP_EN
    bad_tgt  = taken && (br_target[1:0] != 2'b00);
`else
    bad_tgt  = 1'b0;
`endif
    // A redirect that arrives while a fetch is still outstanding is parked
    // until that fetch's handshake retires it.
    buf_wr   = taken && !bad_tgt && !hs &&
               ((state_q == StWait) || (state_q == StRedirect));
    buf_clr  = (state_q == StRedirect) && (hs || bad_tgt);
  end

  redirect_buffer #(
    .XLEN (XLEN)
  ) u_redirect_buffer (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_i        (buf_wr),
    .wr_target_i (tgt),
    .clr_i       (buf_clr),
    .valid_o     (buf_valid),
    .target_o    (buf_target)
  );

  // Sequencer FSM: state, PC and deferred-halt flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StBoot;
      pc_q        <= RESET_PC;
      halt_pend_q <= 1'b0;
    end else begin
      case (state_q)
        StBoot: state_q <= StFetch;
        StFetch: begin
          if (bad_tgt) begin
            state_q <= StHalt;
          end else if (taken) begin
            pc_q    <= tgt;
            state_q <= halt_now ? StHalt : StFetch;
          end else if (stall) begin
            if (halt_now) state_q <= StHalt;
          end else if (hs) begin
            pc_q    <= pc_inc;
            state_q <= halt_now ? StHalt : StFetch;
          end else begin
            state_q     <= StWait;
            halt_pend_q <= halt_now;
          end
        end
        StWait: begin
          if (bad_tgt) begin
            state_q <= StHalt;
          end else if (taken && hs) begin
            pc_q    <= tgt;
            state_q <= halt_now ? StHalt : StFetch;
          end else if (taken) begin
            state_q     <= StRedirect;
            halt_pend_q <= halt_now;
          end else if (hs) begin
            pc_q    <= pc_inc;
            state_q <= halt_now ? StHalt : StFetch;
          end else begin
            halt_pend_q <= halt_now;
          end
        end
        StRedirect: begin
          if (bad_tgt) begin
            state_q <= StHalt;
          end else if (hs) begin
            // The pending fetch is discarded; resume at the youngest target.
            if (taken)          pc_q <= tgt;
            else if (buf_valid) pc_q <= buf_target;
            else                pc_q <= pc_inc;
            state_q <= halt_now ? StHalt : StFetch;
          end else begin
            halt_pend_q <= halt_now;
          end
        end
        StHalt:  state_q <= StHalt;
        default: state_q <= StBoot;
      endcase
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  logic trap_q;

  // Sticky trap flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       trap_q <= 1'b0;
    else if (bad_tgt) trap_q <= 1'b1;
  end

  assign misalign_trap = trap_q;
`endif

  assign pc        = pc_q;
  assign imem_addr = pc_q;
  assign flush     = taken;
  assign halted    = (state_q == StHalt);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed, table-driven bench for pc_sequencer. Each vector is one cycle:
// inputs are driven just after the rising edge, outputs checked on the
// falling edge.
module tb_pc_sequencer;

  localparam int unsigned XLEN = 32;

  typedef struct {
    logic        stall;
    logic        bv;
    logic        nps;
    logic [31:0] tgt;
    logic        halt;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_flush;
    logic        e_halted;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready = 1'b0;
  logic            stall = 1'b0;
  logic            br_valid = 1'b0;
  logic            next_pc_src = 1'b0;
  logic [XLEN-1:0] br_target = '0;
  logic            halt_req = 1'b0;
  logic [XLEN-1:0] pc;
  logic            flush;
  logic            halted;
`ifdef PC_MISALIGN_TRAP_EN
  logic            misalign_trap;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  pc_sequencer #(
    .XLEN     (XLEN),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .stall       (stall),
    .br_valid    (br_valid),
    .next_pc_src (next_pc_src),
    .br_target   (br_target),
    .halt_req    (halt_req),
    .pc          (pc),
    .flush       (flush),
    .halted      (halted)
`ifdef PC_MISALIGN_TRAP_EN
    ,
    .misalign_trap (misalign_trap)
`endif
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic s, input logic bv, input logic nps,
                              input logic [31:0] tgt, input logic h, input logic r,
                              input logic e_req, input logic [31:0] e_addr,
                              input logic e_fl, input logic e_h);
    vec_t v;
    v.stall = s; v.bv = bv; v.nps = nps; v.tgt = tgt; v.halt = h; v.rdy = r;
    v.e_req = e_req; v.e_addr = e_addr; v.e_flush = e_fl; v.e_halted = e_h;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s [%0d]: got 0x%08h, expected 0x%08h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    stall = v.stall; br_valid = v.bv; next_pc_src = v.nps; br_target = v.tgt;
    halt_req = v.halt; imem_ready = v.rdy;
    @(negedge clk);
    check("imem_req", idx, 32'(imem_req), 32'(v.e_req));
    check("imem_addr", idx, imem_addr, v.e_addr);
    check("pc", idx, pc, v.e_addr);
    check("flush", idx, 32'(flush), 32'(v.e_flush));
    check("halted", idx, 32'(halted), 32'(v.e_halted));
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset: outputs must clear without waiting for a clock edge.
  task automatic do_reset(input int idx);
    br_valid = 1'b1; next_pc_src = 1'b1; br_target = 32'h0000_0040; imem_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    check("rst_req", idx, 32'(imem_req), 32'h0);
    check("rst_addr", idx, imem_addr, 32'h0);
    check("rst_flush", idx, 32'(flush), 32'h0);
    check("rst_halted", idx, 32'(halted), 32'h0);
    br_valid = 1'b0; next_pc_src = 1'b0; br_target = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  vec_t tbl[$];
  vec_t seq[$];

  initial begin
    // stall bv nps target halt rdy | req addr flush halted
    tbl.push_back(mk(0, 0, 0, 32'h0,   0, 1, 0, 32'h000, 0, 0)); // BOOT
    tbl.push_back(mk(0, 0, 0, 32'h0,   0, 1, 1, 32'h000, 0, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,   0, 1, 1, 32'h004, 0, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,   0, 1, 1, 32'h008, 0, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,   0, 1, 1, 32'h00C, 0, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,   0, 0, 1, 32'h010, 0, 0)); // ready low x3
    tbl.push_back(mk(0, 0, 0, 32'h0,   0, 0, 1, 32'h010, 0, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,   0, 0, 1, 32'h010, 0, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,   0, 1, 1, 32'h010, 0, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,   0, 1, 1, 32'h014, 0, 0));
    tbl.push_back(mk(0, 1, 1, 32'h200, 0, 1, 1, 32'h018, 1, 0)); // taken in FETCH
    tbl.push_back(mk(0, 0, 0, 32'h0,   0, 1, 1, 32'h200, 0, 0));
    tbl.push_back(mk(0, 1, 0, 32'h300, 0, 1, 1, 32'h204, 0, 0)); // not taken
    tbl.push_back(mk(1, 0, 0, 32'h0,   0, 1, 0, 32'h208, 0, 0)); // stall
    tbl.push_back(mk(1, 0, 0, 32'h0,   0, 1, 0, 32'h208, 0, 0));
    tbl.push_back(mk(1, 1, 1, 32'h400, 0, 1, 0, 32'h208, 1, 0)); // redirect under stall
    tbl.push_back(mk(0, 0, 0, 32'h0,   0, 0, 1, 32'h400, 0, 0));
    tbl.push_back(mk(0, 1, 1, 32'h080, 0, 0, 1, 32'h400, 1, 0)); // redirect in WAIT
    tbl.push_back(mk(0, 0, 0, 32'h0,   0, 0, 1, 32'h400, 0, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,   0, 1, 1, 32'h400, 0, 0)); // discarded fetch
    tbl.push_back(mk(0, 0, 0, 32'h0,   0, 1, 1, 32'h080, 0, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,   0, 0, 1, 32'h084, 0, 0));
    tbl.push_back(mk(0, 1, 1, 32'h500, 0, 0, 1, 32'h084, 1, 0));
    tbl.push_back(mk(0, 1, 1, 32'h600, 0, 0, 1, 32'h084, 1, 0)); // youngest wins
    tbl.push_back(mk(0, 0, 0, 32'h0,   0, 1, 1, 32'h084, 0, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,   0, 1, 1, 32'h600, 0, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,   1, 0, 1, 32'h604, 0, 0)); // halt, not accepted
    tbl.push_back(mk(0, 0, 0, 32'h0,   0, 0, 1, 32'h604, 0, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,   0, 1, 1, 32'h604, 0, 0));
    tbl.push_back(mk(0, 1, 1, 32'h700, 0, 1, 0, 32'h608, 0, 1)); // HALT ignores redirect
    tbl.push_back(mk(0, 0, 0, 32'h0,   0, 1, 0, 32'h608, 0, 1));

    // Wrap-around and simultaneous halt + redirect.
    seq.push_back(mk(0, 0, 0, 32'h0,         0, 1, 0, 32'h0,         0, 0));
    seq.push_back(mk(0, 1, 1, 32'hFFFF_FFFC, 0, 1, 1, 32'h0,         1, 0));
    seq.push_back(mk(0, 0, 0, 32'h0,         0, 1, 1, 32'hFFFF_FFFC, 0, 0));
    seq.push_back(mk(0, 1, 1, 32'h700,       1, 1, 1, 32'h0,         1, 0));
    seq.push_back(mk(0, 0, 0, 32'h0,         0, 1, 0, 32'h700,       0, 1));

    #2;
    do_reset(0);
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    do_reset(100);
    for (int i = 0; i < seq.size(); i++) apply(seq[i], 100 + i);

    // Misaligned redirect target.
    do_reset(200);
    apply(mk(0, 0, 0, 32'h0,   0, 1, 0, 32'h0, 0, 0), 200);
    apply(mk(0, 1, 1, 32'h102, 0, 1, 1, 32'h0, 1, 0), 201);
`ifdef PC_MISALIGN_TRAP_EN
    check("misalign_trap", 202, 32'(misalign_trap), 32'h1);
    apply(mk(0, 0, 0, 32'h0,   0, 1, 0, 32'h0, 0, 1), 202);
    check("misalign_sticky", 203, 32'(misalign_trap), 32'h1);
`else
    apply(mk(0, 0, 0, 32'h0,   0, 1, 1, 32'h100, 0, 0), 202);
    apply(mk(0, 0, 0, 32'h0,   0, 1, 1, 32'h104, 0, 0), 203);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1);
  end

endmodule
